// File: rtl/matmul_seq_engine.sv
// Sequential signed matrix-multiply engine: load A/B rows and C bias, one MAC per cycle, stream results.
// Build option: define MATMUL_SATURATE_EN to clamp overflowed results instead of wrapping them.
module matmul_seq_engine #(
    parameter  int DATA_WIDTH = 8,
    parameter  int BUS_WIDTH  = 32,
    parameter  int ADDR_WIDTH = 32,
    localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
    localparam int DIMW       = $clog2(MAX_DIM)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  mode_i,
    input  logic [DIMW-1:0]       n_dim_i,
    input  logic [DIMW-1:0]       k_dim_i,
    input  logic [DIMW-1:0]       m_dim_i,
    input  logic                  in_valid_i,
    input  logic [BUS_WIDTH-1:0]  data_a_i,
    input  logic [BUS_WIDTH-1:0]  data_b_i,
    input  logic [BUS_WIDTH-1:0]  data_c_i,
    output logic                  busy_o,
    output logic                  enable_w_o,
    output logic [BUS_WIDTH-1:0]  data_o,
    output logic [ADDR_WIDTH-1:0] address_o,
    output logic [BUS_WIDTH-1:0]  flags_o,
    output logic                  finish_mul_o
);
    localparam int ACCW = BUS_WIDTH + 2*DATA_WIDTH;
    localparam int IDXW = 2*DIMW;
    localparam int CNTW = IDXW + 1;
    localparam int NEL  = MAX_DIM*MAX_DIM;

    typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, WRITE, DONE} state_e;

    state_e                  state_q;
    logic [BUS_WIDTH-1:0]    a_q   [MAX_DIM];
    logic [BUS_WIDTH-1:0]    b_q   [MAX_DIM];
    logic [BUS_WIDTH-1:0]    c_q   [NEL];
    logic [BUS_WIDTH-1:0]    res_q [NEL];
    logic signed [ACCW-1:0]  acc_q;
    logic [DIMW-1:0]         n_q, k_q, m_q, i_q, j_q, kk_q;
    logic                    mode_q;
    logic [CNTW-1:0]         beat_q, e_q;

    function automatic logic overflowed(input logic signed [ACCW-1:0] acc);
        logic [ACCW-BUS_WIDTH:0] top;
        top = acc[ACCW-1:BUS_WIDTH-1];
        return !((&top) || !(|top));
    endfunction

    function automatic logic [BUS_WIDTH-1:0] finalize(input logic signed [ACCW-1:0] acc);
`ifdef MATMUL_SATURATE_EN
        if (!overflowed(acc))
            return acc[BUS_WIDTH-1:0];
        return acc[ACCW-1] ? {1'b1, {(BUS_WIDTH-1){1'b0}}} : {1'b0, {(BUS_WIDTH-1){1'b1}}};
`else
        return acc[BUS_WIDTH-1:0];
`endif
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] wr_addr(input logic [IDXW-1:0] idx);
        return {{(ADDR_WIDTH-IDXW-5){1'b0}}, idx, 5'b10000};
    endfunction

    logic [CNTW-1:0]              n1, k1, m1, tot, load_len;
    logic [IDXW-1:0]              eidx, fidx;
    logic signed [DATA_WIDTH-1:0] a_el, b_el;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [BUS_WIDTH-1:0]  c_el;
    logic signed [ACCW-1:0]       acc_base, acc_sum;
    logic                         last_k, last_el, ovf;
    logic [BUS_WIDTH-1:0]         result;
    logic [DIMW-1:0]              i_nx, j_nx;

    assign n1       = CNTW'(n_q) + CNTW'(1);
    assign k1       = CNTW'(k_q) + CNTW'(1);
    assign m1       = CNTW'(m_q) + CNTW'(1);
    assign tot      = n1 * m1;
    // tot >= n+1 always, so the load length only has to compare against k+1
    assign load_len = (k1 > tot) ? k1 : tot;

    // e_q walks the compact row-major order used for C and results; fidx is the padded write index
    assign eidx = e_q[IDXW-1:0];
    assign fidx = IDXW'(i_q) * IDXW'(MAX_DIM) + IDXW'(j_q);

    assign a_el     = a_q[i_q][kk_q*DATA_WIDTH +: DATA_WIDTH];
    assign b_el     = b_q[kk_q][j_q*DATA_WIDTH +: DATA_WIDTH];
    assign prod     = a_el * b_el;
    assign c_el     = c_q[eidx];
    assign acc_base = (kk_q != '0) ? acc_q : (mode_q ? ACCW'(c_el) : '0);
    assign acc_sum  = acc_base + ACCW'(prod);
    assign last_k   = (kk_q == k_q);
    assign last_el  = (i_q == n_q) && (j_q == m_q);
    assign ovf      = overflowed(acc_sum);
    assign result   = finalize(acc_sum);
    assign j_nx     = (j_q == m_q) ? '0 : j_q + 1'b1;
    assign i_nx     = (j_q == m_q) ? i_q + 1'b1 : i_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            for (int r = 0; r < MAX_DIM; r++) begin
                a_q[r] <= '0;
                b_q[r] <= '0;
            end
            for (int r = 0; r < NEL; r++) begin
                c_q[r]   <= '0;
                res_q[r] <= '0;
            end
            acc_q        <= '0;
            n_q          <= '0;
            k_q          <= '0;
            m_q          <= '0;
            i_q          <= '0;
            j_q          <= '0;
            kk_q         <= '0;
            mode_q       <= 1'b0;
            beat_q       <= '0;
            e_q          <= '0;
            busy_o       <= 1'b0;
            enable_w_o   <= 1'b0;
            data_o       <= '0;
            address_o    <= '0;
            flags_o      <= '0;
            finish_mul_o <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    n_q     <= n_dim_i;
                    k_q     <= k_dim_i;
                    m_q     <= m_dim_i;
                    mode_q  <= mode_i;
                    flags_o <= '0;
                    beat_q  <= '0;
                    busy_o  <= 1'b1;
                    state_q <= LOAD;
                end
                LOAD: if (in_valid_i) begin
                    if (beat_q <= CNTW'(n_q)) a_q[beat_q[DIMW-1:0]] <= data_a_i;
                    if (beat_q <= CNTW'(k_q)) b_q[beat_q[DIMW-1:0]] <= data_b_i;
                    if (beat_q < tot)         c_q[beat_q[IDXW-1:0]] <= data_c_i;
                    beat_q <= beat_q + 1'b1;
                    if (beat_q == load_len - 1'b1) begin
                        i_q     <= '0;
                        j_q     <= '0;
                        kk_q    <= '0;
                        e_q     <= '0;
                        state_q <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    acc_q <= acc_sum;
                    if (!last_k) begin
                        kk_q <= kk_q + 1'b1;
                    end else begin
                        kk_q         <= '0;
                        res_q[eidx]  <= result;
                        if (ovf) flags_o[fidx] <= 1'b1;
                        if (!last_el) begin
                            i_q <= i_nx;
                            j_q <= j_nx;
                            e_q <= e_q + 1'b1;
                        end else begin
                            // Registered outputs: present element 0 now; it is still in flight when only one element exists
                            enable_w_o <= 1'b1;
                            data_o     <= (e_q == '0) ? result : res_q[0];
                            address_o  <= wr_addr('0);
                            i_q        <= (m_q == '0) ? DIMW'(1) : '0;
                            j_q        <= (m_q == '0) ? '0 : DIMW'(1);
                            e_q        <= CNTW'(1);
                            state_q    <= WRITE;
                        end
                    end
                end
                WRITE: if (e_q == tot) begin
                    enable_w_o   <= 1'b0;
                    data_o       <= '0;
                    address_o    <= '0;
                    finish_mul_o <= 1'b1;
                    state_q      <= DONE;
                end else begin
                    enable_w_o <= 1'b1;
                    data_o     <= res_q[eidx];
                    address_o  <= wr_addr(fidx);
                    i_q        <= i_nx;
                    j_q        <= j_nx;
                    e_q        <= e_q + 1'b1;
                end
                DONE: begin
                    finish_mul_o <= 1'b0;
                    busy_o       <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matmul_seq_engine.sv
// Scoreboard bench for matmul_seq_engine: directed operations push expected writes, a monitor checks them.
module tb_matmul_seq_engine;
    logic        clk_i = 1'b0;
    logic        rst_ni, start_i, mode_i, in_valid_i;
    logic [1:0]  n_dim_i, k_dim_i, m_dim_i;
    logic [31:0] data_a_i, data_b_i, data_c_i;
    logic        busy_o, enable_w_o, finish_mul_o;
    logic [31:0] data_o, address_o, flags_o;

    always #5 clk_i = ~clk_i;

    matmul_seq_engine #(.DATA_WIDTH(8), .BUS_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .mode_i(mode_i),
        .n_dim_i(n_dim_i), .k_dim_i(k_dim_i), .m_dim_i(m_dim_i),
        .in_valid_i(in_valid_i), .data_a_i(data_a_i), .data_b_i(data_b_i), .data_c_i(data_c_i),
        .busy_o(busy_o), .enable_w_o(enable_w_o), .data_o(data_o), .address_o(address_o),
        .flags_o(flags_o), .finish_mul_o(finish_mul_o)
    );

    typedef struct packed {logic [31:0] d; logic [31:0] a;} wr_t;
    wr_t         exp_q[$];
    int          errors = 0, checks = 0, fin_count = 0;
    logic [31:0] ta[4], tb[4], tc[16];
    logic [31:0] id_exp[16] = '{
        32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80,
        32'h00000078, 32'h00000056, 32'h00000034, 32'h00000012,
        32'hFFFFFF98, 32'hFFFFFFBA, 32'hFFFFFFDC, 32'hFFFFFFFE,
        32'h0000007F, 32'hFFFFFF80, 32'hFFFFFFC3, 32'h00000000};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic exp_wr(input int idx, input logic [31:0] val);
        exp_q.push_back({val, 32'(idx*32 + 16)});
    endtask

    // Monitor: every write strobe pops one expected entry; outside writes data/address must be 0
    always @(negedge clk_i) begin
        wr_t e;
        if (finish_mul_o) fin_count++;
        if (enable_w_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: data %h addr %h, none expected", data_o, address_o);
            end else begin
                e = exp_q.pop_front();
                chk("wr_data", data_o, e.d);
                chk("wr_addr", address_o, e.a);
            end
        end else begin
            chk("idle_data", data_o, 32'h0);
            chk("idle_addr", address_o, 32'h0);
        end
    end

    task automatic begin_op(input int n, input int k, input int m, input bit md, input bit gaps);
        int tot, len;
        tot = (n+1)*(m+1);
        len = (k+1 > tot) ? k+1 : tot;
        @(posedge clk_i); #1;
        start_i = 1'b1; mode_i = md;
        n_dim_i = 2'(n); k_dim_i = 2'(k); m_dim_i = 2'(m);
        @(posedge clk_i); #1;
        start_i = 1'b0; mode_i = ~md;
        n_dim_i = 2'd3; k_dim_i = 2'd3; m_dim_i = 2'd3;
        chk("busy_after_start", {31'b0, busy_o}, 32'd1);
        for (int b = 0; b < len; b++) begin
            if (gaps && (b % 3 == 1)) begin
                in_valid_i = 1'b0;
                data_a_i = 32'hDEADBEEF;
                @(posedge clk_i); #1;
            end
            in_valid_i = 1'b1;
            data_a_i = (b <= n) ? ta[b] : 32'hA5A5A5A5;
            data_b_i = (b <= k) ? tb[b] : 32'h5A5A5A5A;
            data_c_i = (b < tot) ? tc[b] : 32'h7FFFFFFF;
            @(posedge clk_i); #1;
        end
        in_valid_i = 1'b0;
    endtask

    task automatic finish_op(input int n, input int k, input int m, input logic [31:0] exp_flags, input bit poke);
        int cnt, f0;
        f0 = fin_count;
        cnt = 0;
        while (!enable_w_o && cnt < 300) begin
            @(posedge clk_i); #1;
            cnt++;
            if (poke) start_i = (cnt == 3);
        end
        start_i = 1'b0;
        chk("compute_cycles", 32'(cnt), 32'((n+1)*(m+1)*(k+1)));
        cnt = 0;
        while (!finish_mul_o && cnt < 100) begin
            @(posedge clk_i); #1;
            cnt++;
        end
        chk("finish_seen", {31'b0, finish_mul_o}, 32'd1);
        @(posedge clk_i); #1;
        chk("finish_one_cycle", {31'b0, finish_mul_o}, 32'd0);
        chk("busy_in_idle", {31'b0, busy_o}, 32'd0);
        chk("finish_count", 32'(fin_count - f0), 32'd1);
        chk("flags", flags_o, exp_flags);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_busy"}, {31'b0, busy_o}, 32'd0);
        chk({tag, "_en"}, {31'b0, enable_w_o}, 32'd0);
        chk({tag, "_data"}, data_o, 32'h0);
        chk({tag, "_addr"}, address_o, 32'h0);
        chk({tag, "_flags"}, flags_o, 32'h0);
        chk({tag, "_finish"}, {31'b0, finish_mul_o}, 32'd0);
    endtask

    task automatic load_2x2(input logic [31:0] bias);
        ta[0] = 32'h00000201; ta[1] = 32'h00000403;
        tb[0] = 32'h00000605; tb[1] = 32'h00000807;
        for (int i = 0; i < 4; i++) tc[i] = bias;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int f0;
        rst_ni = 1'b0; start_i = 1'b0; mode_i = 1'b0; in_valid_i = 1'b0;
        n_dim_i = '0; k_dim_i = '0; m_dim_i = '0;
        data_a_i = '0; data_b_i = '0; data_c_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check_cleared("reset");
        rst_ni = 1'b1;

        // 2x2x2 without bias
        load_2x2(32'h0);
        begin_op(1, 1, 1, 1'b0, 1'b0);
        exp_wr(0, 32'd19); exp_wr(1, 32'd22); exp_wr(4, 32'd43); exp_wr(5, 32'd50);
        finish_op(1, 1, 1, 32'h0, 1'b0);

        // same operands with bias 1, back to back
        load_2x2(32'd1);
        begin_op(1, 1, 1, 1'b1, 1'b0);
        exp_wr(0, 32'd20); exp_wr(1, 32'd23); exp_wr(4, 32'd44); exp_wr(5, 32'd51);
        finish_op(1, 1, 1, 32'h0, 1'b0);

        // 1x1x1 negative product
        ta[0] = 32'h000000FD; tb[0] = 32'h00000005; tc[0] = 32'h12345678;
        begin_op(0, 0, 0, 1'b0, 1'b0);
        exp_wr(0, 32'hFFFFFFF1);
        finish_op(0, 0, 0, 32'h0, 1'b0);

        // 1x1x1 overflow through the bias
        ta[0] = 32'h00000001; tb[0] = 32'h00000001; tc[0] = 32'h7FFFFFFF;
        begin_op(0, 0, 0, 1'b1, 1'b0);
`ifdef MATMUL_SATURATE_EN
        exp_wr(0, 32'h7FFFFFFF);
`else
        exp_wr(0, 32'h80000000);
`endif
        finish_op(0, 0, 0, 32'h1, 1'b0);

        // reset while idle clears the sticky flag
        @(posedge clk_i); #1;
        rst_ni = 1'b0; #1;
        check_cleared("idle_reset");
        @(posedge clk_i); #1;
        rst_ni = 1'b1;

        // non-square 1x2 * 2x3
        ta[0] = 32'h0000FF02; tb[0] = 32'h00030201; tb[1] = 32'h00060504;
        begin_op(0, 1, 2, 1'b0, 1'b0);
        exp_wr(0, 32'hFFFFFFFE); exp_wr(1, 32'hFFFFFFFF); exp_wr(2, 32'h0);
        finish_op(0, 1, 2, 32'h0, 1'b0);

        // 4x4x4 identity with load gaps and a stray start during COMPUTE
        ta[0] = 32'h80FF7F01; ta[1] = 32'h12345678; ta[2] = 32'hFEDCBA98; ta[3] = 32'h00C3807F;
        for (int r = 0; r < 4; r++) tb[r] = 32'h1 << (8*r);
        for (int i = 0; i < 16; i++) tc[i] = 32'h7FFFFFFF;
        begin_op(3, 3, 3, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) exp_wr(i, id_exp[i]);
        finish_op(3, 3, 3, 32'h0, 1'b1);

        // reset in the middle of COMPUTE: nothing may follow
        load_2x2(32'd1);
        begin_op(1, 1, 1, 1'b1, 1'b0);
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b0; #1;
        check_cleared("mid_reset");
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        f0 = fin_count;
        repeat (20) @(posedge clk_i);
        #1;
        chk("no_finish_after_reset", 32'(fin_count - f0), 32'd0);
        chk("idle_after_reset", {31'b0, busy_o}, 32'd0);

        // first start after reset computes normally
        begin_op(1, 1, 1, 1'b1, 1'b0);
        exp_wr(0, 32'd20); exp_wr(1, 32'd23); exp_wr(4, 32'd44); exp_wr(5, 32'd51);
        finish_op(1, 1, 1, 32'h0, 1'b0);

        repeat (2) @(posedge clk_i);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/matmul_seq_engine.md
MATMUL_SEQ_ENGINE -- requirements
Module: matmul_seq_engine

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 8, operand element width; BUS_WIDTH, default 32, bus and result width; ADDR_WIDTH, default 32, address width; MAX_DIM = BUS_WIDTH/DATA_WIDTH, a localparam; DIMW = clog2(MAX_DIM), a localparam. MAX_DIM*MAX_DIM <= BUS_WIDTH SHALL hold.
REQ-002 clk_i  in  1  clock; all state changes on the rising edge.
REQ-003 rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 start_i  in  1  start request; sampled only in IDLE.
REQ-005 mode_i  in  1  1 = add the C bias to the product; latched at start.
REQ-006 n_dim_i, k_dim_i, m_dim_i  in  DIMW each  matrix dimension minus 1 (A is NxK, B is KxM); latched at start.
REQ-007 in_valid_i  in  1  load beat qualifier.
REQ-008 data_a_i, data_b_i  in  BUS_WIDTH  one row of A and one row of B; element c is at bits [(c+1)*DATA_WIDTH-1 -: DATA_WIDTH], signed.
REQ-009 data_c_i  in  BUS_WIDTH  one signed bias element.
REQ-010 busy_o  out  1  high in any state other than IDLE.
REQ-011 enable_w_o, data_o, address_o  out  1 / BUS_WIDTH / ADDR_WIDTH  result write strobe, result data, result address.
REQ-012 flags_o  out  BUS_WIDTH  per-element overflow flags; bit index = i*MAX_DIM+j.
REQ-013 finish_mul_o  out  1  one-cycle completion pulse.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, COMPUTE, WRITE and DONE; the only transitions SHALL be IDLE->LOAD, LOAD->COMPUTE, COMPUTE->WRITE, WRITE->DONE and DONE->IDLE.
REQ-015 IDLE with start_i=1 SHALL latch the dims and mode_i, clear flags_o and the beat counter, and enter LOAD; start_i outside IDLE SHALL be ignored.
REQ-016 LOAD: each beat b (in_valid_i=1) SHALL store A row b if b<=n, B row b if b<=k, and C element b (row-major, index i*(m+1)+j) if b<(n+1)(m+1).
REQ-017 LOAD SHALL exit to COMPUTE on the cycle after beat number L-1, where L = max(n+1, k+1, (n+1)(m+1)); cycles with in_valid_i=0 SHALL stall the load; in_valid_i outside LOAD SHALL be ignored.
REQ-018 COMPUTE SHALL process elements (i,j) in row-major order and SHALL perform one signed MAC per cycle, k+1 cycles per element.
REQ-019 The accumulator SHALL start at C(i,j) when mode=1 and at 0 when mode=0, and SHALL be BUS_WIDTH+2*DATA_WIDTH bits wide.
REQ-020 At the end of each element, if the accumulator is outside the signed BUS_WIDTH range, flags_o[i*MAX_DIM+j] SHALL be set and SHALL stay set until the next accepted start.
REQ-021 COMPUTE SHALL take exactly (n+1)(m+1)(k+1) cycles, then enter WRITE.
REQ-022 WRITE SHALL output one valid element per cycle in row-major order, with enable_w_o=1, address_o[4:0]=5'b10000, address_o[5+2*DIMW-1:5]=i*MAX_DIM+j, all other address bits 0, and data_o=result. WRITE SHALL last (n+1)(m+1) cycles; elements outside the dims SHALL NOT be written.
REQ-023 DONE SHALL last one cycle with finish_mul_o=1, then return to IDLE.
REQ-024 Outside WRITE, enable_w_o, data_o and address_o SHALL be 0; flags_o SHALL hold its value through IDLE.
REQ-025 Back-to-back operation: start_i=1 in the IDLE cycle after DONE SHALL be accepted.

Reset
REQ-026 rst_ni=0 SHALL asynchronously force IDLE and clear all operand storage, the accumulator, the counters and all outputs to 0, including in the middle of an operation; no write or finish pulse SHALL follow.
REQ-027 After reset release, the first start_i SHALL be accepted normally.

Configuration
REQ-028 With MATMUL_SATURATE_EN defined, an overflowed result SHALL be clamped to the signed BUS_WIDTH max or min. Without it, the result SHALL be the low BUS_WIDTH bits (wrap). Flags SHALL be identical in both builds.

Verification (DATA_WIDTH=8, BUS_WIDTH=32, MAX_DIM=4)
REQ-029 2x2x2, mode=0, A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> writes 19,22,43,50 at indices 0,1,4,5; COMPUTE lasts 8 cycles; flags=0; one finish pulse.
REQ-030 Same operands, mode=1, C=[1,1,1,1] -> writes 20,23,44,51.
REQ-031 1x1x1, A=-3, B=5, mode=0 -> data_o=0xFFFFFFF1 at index 0, flags=0.
REQ-032 1x1x1, A=1, B=1, mode=1, C=0x7FFFFFFF -> flags_o[0]=1; data_o=0x80000000 (wrap build) or 0x7FFFFFFF (MATMUL_SATURATE_EN build).
REQ-033 4x4x4, B=identity, A rows random -> 16 writes equal to A, COMPUTE lasts 64 cycles; in_valid_i gaps during LOAD only delay the load.
REQ-034 start_i pulsed during COMPUTE -> ignored. rst_ni asserted mid-COMPUTE -> all outputs 0, state IDLE. A following start -> correct result.
